// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: host writes land in a circular FIFO and are
// serialized on tx back-to-back, with no idle gap between queued frames.
module uart_tx_buffered #(
    parameter int CLOCK_DIVIDE = 1302,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               transmit,
    input  logic [7:0]         tx_byte,
    output logic               tx,
    output logic               is_transmitting,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [15:0]      DIV_LAST   = 16'(CLOCK_DIVIDE - 1);
    localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
    logic             empty, push, pop;

    state_t      state, state_next;
    logic [15:0] div_cnt, div_next;
    logic [2:0]  bit_cnt, bit_next;
    logic [7:0]  shift, shift_next;
    logic        tx_next;
    logic        div_end;

    // Pointers carry one extra bit so that full and empty stay distinguishable.
    assign count      = wr_ptr - rd_ptr;
    assign fifo_count = count;
    assign fifo_full  = (count == COUNT_FULL);
    assign empty      = (count == '0);
    assign push       = transmit && !fifo_full;
    assign div_end    = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            overflow <= transmit && fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
        end else begin
            state           <= state_next;
            div_cnt         <= div_next;
            bit_cnt         <= bit_next;
            shift           <= shift_next;
            tx              <= tx_next;
            is_transmitting <= (state_next != IDLE);
        end
    end

    // The shift register moves right as each data bit is launched, so the
    // next bit to send is always shift[0].
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        tx_next    = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr[FIFO_AW-1:0]];
                    tx_next    = 1'b0;
                    div_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (div_end) begin
                    div_next   = '0;
                    tx_next    = shift[0];
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    div_next = div_cnt + 16'd1;
                end
            end
            DATA: begin
                if (div_end) begin
                    div_next = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        tx_next    = shift[0];
                        shift_next = {1'b0, shift[7:1]};
                        bit_next   = bit_cnt + 3'd1;
                    end
                end else begin
                    div_next = div_cnt + 16'd1;
                end
            end
            STOP: begin
                if (div_end) begin
                    div_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr[FIFO_AW-1:0]];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed and random writes checked every cycle
// against a frame-timeline model (byte queue plus elapsed-cycles-in-frame).
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       transmit_a, transmit_b;
    logic [7:0] byte_a, byte_b;
    logic       tx_a, busy_a, full_a, ovf_a;
    logic       tx_b, busy_b, full_b, ovf_b;
    logic [4:0] count_a, count_b;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLOCK_DIVIDE(4), .FIFO_AW(4)) dut_a (
        .clk(clk), .rst(rst), .transmit(transmit_a), .tx_byte(byte_a),
        .tx(tx_a), .is_transmitting(busy_a), .fifo_full(full_a),
        .fifo_count(count_a), .overflow(ovf_a)
    );

    uart_tx_buffered #(.CLOCK_DIVIDE(2), .FIFO_AW(4)) dut_b (
        .clk(clk), .rst(rst), .transmit(transmit_b), .tx_byte(byte_b),
        .tx(tx_b), .is_transmitting(busy_b), .fifo_full(full_b),
        .fifo_count(count_b), .overflow(ovf_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] q[$];
    bit         in_frame   = 0;
    logic [7:0] frame_byte = 8'h00;
    int         elapsed    = 0;
    bit         exp_ovf    = 0;
    int         cd         = 4;
    int         sel        = 0;

    // Line level as a function of position within the 10-bit frame.
    function automatic logic model_tx();
        int bi;
        if (!in_frame) return 1'b1;
        bi = elapsed / cd;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return frame_byte[bi-1];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic [7:0] b, input logic r);
        bit full, ending;
        rst = r;
        if (sel == 0) begin
            transmit_a = t; byte_a = b; transmit_b = 1'b0; byte_b = 8'h00;
        end else begin
            transmit_b = t; byte_b = b; transmit_a = 1'b0; byte_a = 8'h00;
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            in_frame = 0;
            elapsed  = 0;
            exp_ovf  = 0;
        end else begin
            full   = (q.size() == 16);
            ending = in_frame && (elapsed == 10 * cd - 1);
            if ((!in_frame || ending) && q.size() > 0) begin
                frame_byte = q.pop_front();
                in_frame   = 1;
                elapsed    = 0;
            end else if (ending) begin
                in_frame = 0;
            end else if (in_frame) begin
                elapsed++;
            end
            if (t && !full) q.push_back(b);
            exp_ovf = t && full;
        end
        #1;
        checkOutput("tx",    sel ? tx_b    : tx_a,    model_tx());
        checkOutput("busy",  sel ? busy_b  : busy_a,  in_frame);
        checkOutput("count", sel ? count_b : count_a, q.size());
        checkOutput("full",  sel ? full_b  : full_a,  q.size() == 16);
        checkOutput("ovf",   sel ? ovf_b   : ovf_a,   exp_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((in_frame || q.size() > 0) && i < 2000) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            i++;
        end
        if (in_frame || q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL drain_timeout: observed busy after %0d cycles expected idle", i);
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b1; transmit_a = 1'b0; transmit_b = 1'b0; byte_a = 8'h00; byte_b = 8'h00;
        sel = 0; cd = 4;
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(2);

        $display("[TB] single frame 0x55");
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("t1_lat0", tx_a, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1_lat1", tx_a, 1'b0);
        checkOutput("t1_count", count_a, 5'd0);
        drain();

        $display("[TB] back-to-back A3 00 FF");
        applyStimulus(1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        drain();

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 18; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("t3_count", count_a, 5'd16);
        checkOutput("t3_full", full_a, 1'b1);
        checkOutput("t3_ovf", ovf_a, 1'b1);
        begin
            int i;
            i = 0;
            while (!(in_frame && elapsed == 10 * cd - 1) && i < 100) begin
                applyStimulus(1'b0, 8'h00, 1'b0);
                i++;
            end
            if (!(in_frame && elapsed == 10 * cd - 1)) begin
                tests_run++;
                tests_failed++;
                $error("[TB] FAIL t4_timeout: observed no frame end in %0d cycles", i);
            end
        end
        applyStimulus(1'b1, 8'h7E, 1'b0);
        checkOutput("t4_count_drop", count_a, 5'd15);
        checkOutput("t4_ovf", ovf_a, 1'b1);
        applyStimulus(1'b1, 8'h7E, 1'b0);
        checkOutput("t4_count_retry", count_a, 5'd16);
        checkOutput("t4_ovf_clear", ovf_a, 1'b0);
        drain();

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        while (!(in_frame && elapsed == 17)) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_tx", tx_a, 1'b1);
        checkOutput("t5_busy", busy_a, 1'b0);
        checkOutput("t5_count", count_a, 5'd0);
        idle(50);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, 8'($urandom), 1'b0);
        end
        drain();

        $display("[TB] minimum divide 0x81");
        sel = 1; cd = 2;
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(2);
        applyStimulus(1'b1, 8'h81, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t6_start", tx_b, 1'b0);
        drain();
        for (int i = 0; i < 120; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered 8N1 UART transmitter. Its byte-level input (transmit strobe, tx_byte, is_transmitting) matches the transmit side of the existing uart core. Bytes written by a host are queued in an internal FIFO and serialized on tx back-to-back, with no host pacing. It sits between the application logic (e.g. a command responder) and the serial pin, in place of the core's unbuffered transmit path.

Parameters:
CLOCK_DIVIDE, 1302, clk cycles per serial bit (e.g. 50 MHz / 38400). Legal range 2..65535.
FIFO_AW, 4, log2 of FIFO depth; depth = 2**FIFO_AW = 16 bytes.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
transmit  input  1  write strobe; pushes tx_byte when high on a clock edge
tx_byte  input  8  byte to queue; sampled only with transmit
tx  output  1  serial line; idle high
is_transmitting  output  1  high while a frame (start..stop) is on tx
fifo_full  output  1  FIFO holds 2**FIFO_AW bytes
fifo_count  output  FIFO_AW+1  number of queued bytes, excluding the byte in flight
overflow  output  1  one-cycle pulse: a write was dropped because the FIFO was full

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - tx=1, is_transmitting=0, fifo_count=0, fifo_full=0, overflow=0.
  - FSM goes to IDLE; all counters and pointers clear.
  - Asserted mid-frame: the frame aborts, tx=1 after that edge, FIFO contents are discarded.
- FIFO:
  - Circular buffer, read/write pointers FIFO_AW+1 bits wide.
  - full = (count == 2**FIFO_AW); empty = (count == 0).
  - Push: on an edge with transmit=1 and full=0, tx_byte is written and count increments.
  - Push while full: data dropped, count unchanged, overflow=1 for exactly the next cycle. This holds even if a pop happens in the same cycle (full is evaluated from the pre-edge state).
  - Simultaneous push and pop, not full: count unchanged and data order preserved. This includes the case count=1, where the popped byte is the old head.
- FSM states:
  - IDLE: tx=1, is_transmitting=0. If the FIFO is non-empty at an edge: pop the head into the shift register, tx<=0, div_cnt<=0, go to START.
  - START: tx=0 for CLOCK_DIVIDE cycles; then tx<=shift[0], bit_cnt<=0, go to DATA.
  - DATA: each bit is held CLOCK_DIVIDE cycles, LSB first. After bit 7: tx<=1, go to STOP.
  - STOP: tx=1 for CLOCK_DIVIDE cycles. At the end, if the FIFO is non-empty, pop and go directly to START with tx<=0 (zero idle gap); otherwise go to IDLE.
- Timing:
  - div_cnt counts 0..CLOCK_DIVIDE-1 and advances state when div_cnt==CLOCK_DIVIDE-1.
  - Frame length is exactly 10*CLOCK_DIVIDE cycles.
  - Latency: a push on edge E0 into an idle, empty block makes tx fall after edge E1.
- is_transmitting is registered; it is 1 in START, DATA and STOP and 0 in IDLE. It stays 1 continuously across back-to-back frames.
- tx is driven directly from a register (glitch-free).

Test Plan:
1. CLOCK_DIVIDE=4: push 0x55 once -> tx falls one edge later; serial bits 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 4 cycles; is_transmitting high 40 cycles; fifo_count returns to 0 after the pop.
2. Push 0xA3, 0x00, 0xFF on consecutive cycles -> three frames with no idle gap (120 cycles at divide 4); decoded bytes 0xA3, 0x00, 0xFF in order; is_transmitting never drops between frames.
3. Hold transmit for 18 cycles with bytes 0x01..0x12 while idle -> the first byte pops at the first opportunity, 16 are queued, fifo_full=1, and overflow pulses for the final dropped write. Output order is 0x01..0x11; 0x12 is never sent.
4. FIFO full, mid-frame: on the STOP-end pop edge, push 0x7E -> the write is dropped, overflow pulses, count goes 16->15. An immediate retry succeeds, count 15->16.
5. Assert rst for 1 cycle during DATA bit 3 with 5 bytes queued -> tx=1, is_transmitting=0, fifo_count=0 after the edge; no further frames; a new push 0x3C transmits correctly.
6. CLOCK_DIVIDE=2 (minimum): push 0x81 -> bit widths are exactly 2 cycles; frame is 20 cycles; data bits are 1,0,0,0,0,0,0,1.
